// File: rtl/timer_counter.sv
// Memory-mapped 32-bit countdown timer with a level interrupt.
// Register window: CTRL (rw), PRESET (rw), COUNT (ro), reserved (reads 0).
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;

  logic        sel;
  logic [1:0]  offset;
  logic        wr_en;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_reload;
  logic        en_clr;
  logic        unused_addr_bits;

  assign sel              = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset           = addr[3:2];
  assign wr_en            = sel && (byteen != 4'b0000);
  assign ctrl_wr          = wr_en && (offset == 2'd0);
  assign preset_wr        = wr_en && (offset == 2'd1);
  assign auto_reload      = (ctrl_q[2:1] == 2'b01);
  assign unused_addr_bits = ^addr[1:0];

  assign irq = pending_q & ctrl_q[3];

  // Combinational read mux over current register values
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = '0;
      endcase
    end
  end

  // FSM next state plus count/pending updates, then software writes layered on top
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = pending_q;
    en_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q == 32'd0) begin
          state_d   = S_INT;
          pending_d = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          state_d   = S_LOAD;
          pending_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          en_clr  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Software writes are applied after the FSM so a written EN overrides the
    // one-shot auto-clear and a CTRL write's pending clear beats a new expiry.
    ctrl_d = ctrl_q;
    if (en_clr) ctrl_d[0] = 1'b0;
    if (ctrl_wr) begin
      pending_d = 1'b0;
      if (byteen[0]) ctrl_d = wdata[3:0];
    end

    preset_d = preset_q;
    if (preset_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Register update with synchronous reset taking priority over writes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter using scenario-level arithmetic expectations.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks;
  int errors;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a write; returns #1 after the edge that performs it
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr   = a;
    wdata  = d;
    byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr   = a;
    byteen = 4'b0000;
    #1;
    d = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles with writes active so reset must win over them
  task automatic do_reset();
    reset  = 1'b1;
    addr   = BASE;
    wdata  = $urandom | 32'h1;
    byteen = 4'hF;
    @(posedge clk);
    addr   = BASE + 32'h4;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    byteen = 4'b0000;
  endtask

  // Expected COUNT t edges after the EN write, for a run that started from COUNT=0
  function automatic logic [31:0] exp_count(input int t, input int p, input bit reload);
    int k;
    if (t < 2) return 32'd0;
    k = t - 2;
    if (reload) k = k % (p + 3);
    if (k <= p) return 32'(p - k);
    return 32'd0;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    wr(BASE + 32'h4, $urandom, 4'hF);
    wr(BASE, 32'h9, 4'hF);
    repeat (3) tick();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rd(BASE + 32'(4 * i), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected 00000000", i, d);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int p;
    int mode;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      p = (it == 0) ? 0 : (it == 1) ? 5 : $urandom_range(1, 12);
      mode = (it == 1) ? 0 : $urandom_range(0, 2);
      if (mode == 1) mode = 3;
      wr(BASE + 32'h4, 32'(p), 4'hF);
      wr(BASE, 32'(8 | (mode << 1) | 1), 4'hF);
      for (int t = 1; t <= p + 6; t++) begin
        tick();
        checks++;
        if (irq !== (t >= p + 3)) begin
          errors++;
          $display("FAIL oneshot_irq p=%0d t=%0d: got %b expected %b", p, t, irq, (t >= p + 3));
        end
        rd(BASE + 32'h8, d);
        checks++;
        if (d !== exp_count(t, p, 1'b0)) begin
          errors++;
          $display("FAIL oneshot_count p=%0d t=%0d: got %0d expected %0d", p, t, d, exp_count(t, p, 1'b0));
        end
      end
      rd(BASE, d);
      checks++;
      if (d !== 32'(8 | (mode << 1))) begin
        errors++;
        $display("FAIL oneshot_ctrl: got %h expected %h", d, 32'(8 | (mode << 1)));
      end
      wr(BASE, 32'h8, 4'h1);
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_irq_clear: got %b expected 0", irq);
      end
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    int p;
    int len;
    bit exp_irq;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      p = (it == 0) ? 3 : $urandom_range(0, 6);
      len = p + 3;
      wr(BASE + 32'h4, 32'(p), 4'hF);
      wr(BASE, 32'hB, 4'hF);
      for (int t = 1; t <= 4 * len + 2; t++) begin
        tick();
        exp_irq = (t >= len) && (((t - len) % len) == 0);
        checks++;
        if (irq !== exp_irq) begin
          errors++;
          $display("FAIL reload_irq p=%0d t=%0d: got %b expected %b", p, t, irq, exp_irq);
        end
        rd(BASE + 32'h8, d);
        checks++;
        if (d !== exp_count(t, p, 1'b1)) begin
          errors++;
          $display("FAIL reload_count p=%0d t=%0d: got %0d expected %0d", p, t, d, exp_count(t, p, 1'b1));
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    logic [31:0] model;
    logic [31:0] nd;
    logic [3:0]  be;
    do_reset();
    model = 32'h1122_3344;
    wr(BASE + 32'h4, model, 4'hF);
    wr(BASE + 32'h4, 32'h00AA_0000, 4'b0100);
    model[23:16] = 8'hAA;
    rd(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h11AA_3344) begin
      errors++;
      $display("FAIL lanes_fixed: got %h expected 11aa3344", d);
    end
    for (int i = 0; i < 6; i++) begin
      be = 4'($urandom_range(1, 15));
      nd = $urandom;
      wr(BASE + 32'h4, nd, be);
      for (int l = 0; l < 4; l++)
        if (be[l]) model[8*l +: 8] = nd[8*l +: 8];
      rd(BASE + 32'h4, d);
      checks++;
      if (d !== model) begin
        errors++;
        $display("FAIL lanes_rand be=%b: got %h expected %h", be, d, model);
      end
    end
    wr(BASE + 32'h8, $urandom | 32'h1, 4'hF);
    wr(BASE + 32'hC, $urandom | 32'h1, 4'hF);
    rd(BASE + 32'h8, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL count_ro: got %h expected 00000000", d);
    end
    rd(BASE + 32'hC, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reserved_reg: got %h expected 00000000", d);
    end
    wr(BASE, 32'hFFFF_FFF4, 4'hF);
    wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0000_8F00, 32'hFFFF_FFFF, 4'hF);
    rd(BASE, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL ctrl_upper_and_unsel: got %h expected 00000004", d);
    end
    rd(BASE + 32'h14, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL unselected_read: got %h expected 00000000", d);
    end
  endtask

  task automatic test_abort_mask();
    logic [31:0] d;
    int w;
    int p;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      w = (it == 0) ? 52 : $urandom_range(5, 90);
      wr(BASE + 32'h4, 32'd100, 4'hF);
      wr(BASE, 32'h1, 4'hF);
      for (int t = 1; t < w; t++) tick();
      wr(BASE, 32'h0, 4'hF);
      for (int t = 0; t < 5; t++) begin
        tick();
        rd(BASE + 32'h8, d);
        checks++;
        if (d !== 32'(100 - (w - 2)) || irq !== 1'b0) begin
          errors++;
          $display("FAIL abort_hold w=%0d: got count %0d irq %b expected count %0d irq 0", w, d, irq, 100 - (w - 2));
        end
      end
    end
    do_reset();
    p = $urandom_range(0, 8);
    wr(BASE + 32'h4, 32'(p), 4'hF);
    wr(BASE, 32'h1, 4'hF);
    for (int t = 1; t <= p + 6; t++) begin
      tick();
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL masked_irq t=%0d: got %b expected 0", t, irq);
      end
    end
    rd(BASE, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL masked_expired_ctrl: got %h expected 00000000", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    int p;
    do_reset();
    p = $urandom_range(1, 6);
    wr(BASE + 32'h4, 32'(p), 4'hF);
    wr(BASE, 32'h9, 4'hF);
    for (int t = 1; t <= p + 3; t++) tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL collision_int_irq: got %b expected 1", irq);
    end
    wr(BASE, 32'h9, 4'h1);
    rd(BASE, d);
    checks++;
    if (d !== 32'h9 || irq !== 1'b0) begin
      errors++;
      $display("FAIL collision_ctrl: got ctrl %h irq %b expected ctrl 00000009 irq 0", d, irq);
    end
    for (int t = 1; t <= p + 4; t++) begin
      tick();
      rd(BASE + 32'h8, d);
      checks++;
      if (d !== exp_count(t, p, 1'b0) || irq !== (t >= p + 3)) begin
        errors++;
        $display("FAIL collision_rerun t=%0d: got count %0d irq %b expected count %0d irq %b",
                 t, d, irq, exp_count(t, p, 1'b0), (t >= p + 3));
      end
    end
    do_reset();
    wr(BASE + 32'h4, 32'd50, 4'hF);
    wr(BASE, 32'h9, 4'hF);
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      rd(BASE + 32'h8, d);
      checks++;
      if (d !== 32'd0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL midcount_reset t=%0d: got count %0d irq %b expected count 0 irq 0", t, d, irq);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    addr   = '0;
    wdata  = '0;
    byteen = 4'b0000;
    do_reset();
    test_reset();
    test_oneshot();
    test_autoreload();
    test_byte_lanes();
    test_abort_mask();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
